// File: rtl/dtree_seq_classifier.sv
// dtree_seq_classifier
//   Table-driven decision-tree classifier. Node words live in a writable
//   register table and one node is visited per clock. The root is node 0.
//   Ports:
//     clk, rst                  clock (rising edge), async active-high reset
//     cfg_we/cfg_addr/cfg_wdata node-table write, honoured only while cfg_ready
//     cfg_ready                 high in IDLE
//     in_valid/in_ready/in_feat feature vector handshake (feature k at [k*FEAT_W +: FEAT_W])
//     out_valid/out_ready       result handshake
//     out_class/out_err/out_depth  class, abort flag, internal nodes traversed
//   Node word (MSB first): INT | FIDX | SHIFT(3) | THR | CHILD
module dtree_seq_classifier #(
  parameter int N_FEAT    = 18,
  parameter int FEAT_W    = 8,
  parameter int NODE_AW   = 6,
  parameter int CLASS_W   = 2,
  parameter int MAX_DEPTH = 15,
  localparam int FIDX_W   = $clog2(N_FEAT),
  localparam int WORD_W   = 1 + FIDX_W + 3 + FEAT_W + NODE_AW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_we,
  input  logic [NODE_AW-1:0]       cfg_addr,
  input  logic [WORD_W-1:0]        cfg_wdata,
  output logic                     cfg_ready,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_FEAT*FEAT_W-1:0] in_feat,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CLASS_W-1:0]       out_class,
  output logic                     out_err,
  output logic [3:0]               out_depth
);

  localparam int N_NODES = 2 ** NODE_AW;

  typedef enum logic [1:0] {IDLE, WALK, DONE} state_e;

  state_e                               state_q;
  logic [N_NODES-1:0][WORD_W-1:0]       tbl_q;
  logic [N_FEAT-1:0][FEAT_W-1:0]        feat_q;
  logic [NODE_AW-1:0]                   ptr_q;
  logic [3:0]                           depth_q;

  // Current node decode (combinational table read)
  logic [WORD_W-1:0]  node;
  logic               n_int;
  logic [FIDX_W-1:0]  n_fidx;
  logic [2:0]         n_shift;
  logic [FEAT_W-1:0]  n_thr;
  logic [NODE_AW-1:0] n_child;
  logic [FEAT_W-1:0]  fval;
  logic               fidx_bad;
  logic               test_true;
  logic               abort;
  logic [NODE_AW-1:0] ptr_d;

  always_comb begin
    node      = tbl_q[ptr_q];
    n_int     = node[WORD_W-1];
    n_fidx    = node[WORD_W-2 -: FIDX_W];
    n_shift   = node[NODE_AW+FEAT_W +: 3];
    n_thr     = node[NODE_AW +: FEAT_W];
    n_child   = node[NODE_AW-1:0];
    // Extra MSB so the bound check holds even when N_FEAT is a power of two
    fidx_bad  = {1'b0, n_fidx} >= (FIDX_W+1)'(N_FEAT);
    fval      = fidx_bad ? '0 : feat_q[n_fidx];
    test_true = (fval >> n_shift) <= n_thr;
    abort     = (depth_q == 4'(MAX_DEPTH)) || fidx_bad;
    // False branch goes to CHILD+1; NODE_AW-bit arithmetic gives the wrap
    ptr_d     = test_true ? n_child : n_child + 1'b1;
  end

  assign in_ready  = (state_q == IDLE);
  assign cfg_ready = (state_q == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      tbl_q     <= '0;
      feat_q    <= '0;
      ptr_q     <= '0;
      depth_q   <= '0;
      out_valid <= 1'b0;
      out_class <= '0;
      out_err   <= 1'b0;
      out_depth <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cfg_we) tbl_q[cfg_addr] <= cfg_wdata;
          if (in_valid) begin
            feat_q  <= in_feat;
            ptr_q   <= '0;
            depth_q <= '0;
            state_q <= WALK;
          end
        end
        WALK: begin
          if (!n_int) begin
            out_class <= n_thr[CLASS_W-1:0];
            out_err   <= 1'b0;
            out_depth <= depth_q;
            out_valid <= 1'b1;
            state_q   <= DONE;
          end else if (abort) begin
            out_class <= '0;
            out_err   <= 1'b1;
            out_depth <= depth_q;
            out_valid <= 1'b1;
            state_q   <= DONE;
          end else begin
            ptr_q   <= ptr_d;
            depth_q <= depth_q + 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
